// File: rtl/fpu_pkg.sv
// Shared float32 field layout, constants and state encoding for the
// float-to-BCD display path.
package fpu_pkg;

  localparam int unsigned EXP_BIAS    = 127;
  localparam int unsigned FRAC_W      = 23;
  localparam logic [7:0]  EXP_INF_NAN = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [FRAC_W-1:0] frac;
  } float32_t;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    StIdle,
    StUnpack,
    StConvert,
    StDone
  } disp_state_e;

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
// the combined {bcd, bin} register left by one bit.
module bcd_dd_step import fpu_pkg::*; #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BIN_W    = 14
) (
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic [BIN_W-1:0]      bin_out
);

  logic [4*N_DIGITS-1:0] adj;
  bcd_digit_t            digit;

  always_comb begin
    adj   = bcd_in;
    digit = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      digit = bcd_in[4*i +: 4];
      if (digit >= 4'd5) begin
        adj[4*i +: 4] = digit + 4'd3;
      end
    end
    {bcd_out, bin_out} = {adj, bin_in} << 1;
  end

endmodule

// File: rtl/fp32_to_bcd_disp.sv
// Converts one float32 to sign/overflow flags plus packed BCD in tenths,
// using a sequential double-dabble engine (one bit per cycle).
module fp32_to_bcd_disp import fpu_pkg::*; #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BIN_W    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_float32,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf
);

  localparam int unsigned BCD_W  = 4 * N_DIGITS;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
  localparam int unsigned SAT_I  = 10 ** N_DIGITS - 1;
  localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(SAT_I);

  disp_state_e       state_q;
  float32_t          float_q;
  logic [BIN_W-1:0]  bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;
  logic              ovf_q;

  logic [23:0]       mant;
  logic [27:0]       prod;
  logic signed [9:0] sh;
  logic [32:0]       rnd_sum;
  logic [32:0]       rnd_val;
  logic [BIN_W-1:0]  val_d;
  logic              neg_d;
  logic              ovf_d;

  logic [BCD_W-1:0]  step_bcd;
  logic [BIN_W-1:0]  step_bin;

  assign in_ready = (state_q == StIdle) && !rst;

  // Magnitude * 10, then round half up at the binary point given by sh.
  always_comb begin
    mant    = {1'b1, float_q.frac};
    prod    = {1'b0, mant, 3'b000} + {3'b000, mant, 1'b0};
    sh      = 10'(EXP_BIAS + FRAC_W) - {2'b00, float_q.exp};
    rnd_sum = {5'b00000, prod} + (33'd1 << (sh[4:0] - 5'd1));
    rnd_val = rnd_sum >> sh[4:0];
    val_d   = '0;
    neg_d   = 1'b0;
    ovf_d   = 1'b0;
    if (float_q.exp == EXP_INF_NAN) begin
      ovf_d = 1'b1;
      val_d = SAT_VAL;
    end else if ((float_q.exp != 8'd0) && (sh <= 10'sd31)) begin
      neg_d = float_q.sign;
      if ((sh <= 10'sd0) || (rnd_val > 33'(SAT_I))) begin
        ovf_d = 1'b1;
        val_d = SAT_VAL;
      end else begin
        val_d = rnd_val[BIN_W-1:0];
      end
    end
    if (val_d == '0) begin
      neg_d = 1'b0;
    end
  end

  bcd_dd_step #(
    .N_DIGITS (N_DIGITS),
    .BIN_W    (BIN_W)
  ) u_step (
    .bcd_in  (bcd_q),
    .bin_in  (bin_q),
    .bcd_out (step_bcd),
    .bin_out (step_bin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      float_q   <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_neg   <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            float_q <= in_float32;
            state_q <= StUnpack;
          end
        end
        StUnpack: begin
          bin_q   <= val_d;
          bcd_q   <= '0;
          neg_q   <= neg_d;
          ovf_q   <= ovf_d;
          cnt_q   <= '0;
          state_q <= StConvert;
        end
        StConvert: begin
          bcd_q <= step_bcd;
          bin_q <= step_bin;
          cnt_q <= cnt_q + CNT_W'(1);
          // Last iteration: capture the finished BCD straight from the step.
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            out_bcd   <= step_bcd;
            out_neg   <= neg_q;
            out_ovf   <= ovf_q;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/fp32_to_bcd_disp.md
Name: fp32_to_bcd_disp

Overview:
Downstream consumer of the Celsius-to-Fahrenheit converter's float32 result. Accepts one IEEE-754 single-precision value over a valid/ready handshake. Rounds its magnitude to one fractional decimal digit and converts it to packed BCD with a sequential double-dabble engine. Output is a sign flag, an overflow flag and BCD digits, which feed the display driver.

Parameters:
N_DIGITS, 4, total BCD digits output, including one fractional (tenths) digit; saturation value = 10^N_DIGITS - 1 (in tenths).
BIN_W, 14, width of the rounded binary value; must be >= ceil(log2(10^N_DIGITS)).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_float32 valid
in_ready  out  1  block can accept; = (state==IDLE) && !rst
in_float32  in  32  IEEE-754 single operand
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  consumer accepts result
out_bcd  out  4*N_DIGITS  packed BCD; [3:0] = tenths, then units, tens, hundreds (MSD at top)
out_neg  out  1  result negative
out_ovf  out  1  saturated (NaN/Inf/out of range)

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; out_valid=0, out_bcd=0, out_neg=0, out_ovf=0; internal shift/count regs cleared. Reset in any state, including mid-CONVERT or DONE, aborts the conversion and drops the result.
- FSM: IDLE -> UNPACK -> CONVERT -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid && in_ready at an edge, latch in_float32 and go to UNPACK.
- UNPACK (1 cycle): with s=sign, e=exponent, M={1,frac} (24b), P=M*10 (28b, shift-add), sh=150-e:
  - e==255: ovf=1, neg=0, value10 = 10^N_DIGITS - 1.
  - e==0 (zero/denormal): value10=0.
  - sh>31: value10=0.
  - sh<=0, or the rounded value > 10^N_DIGITS - 1: ovf=1, value10 = 10^N_DIGITS - 1, neg=s.
  - otherwise: value10 = (P + (1<<(sh-1))) >> sh, i.e. round half up on magnitude.
  - neg forced 0 whenever value10==0, so -0.0 is never shown.
  - Go to CONVERT with count=0.
- CONVERT: BIN_W cycles. Each cycle applies add-3 to every BCD digit >=5, then shifts the {bcd, bin} register left by 1. After BIN_W iterations, go to DONE.
- DONE: out_bcd/out_neg/out_ovf are registered on DONE entry, and out_valid=1. Outputs stay stable while out_ready=0. The edge with out_valid && out_ready goes to IDLE and clears out_valid. out_bcd/neg/ovf keep their last value until the next DONE entry.
- Latency: accept at edge k -> out_valid high from edge k+1+BIN_W (15 cycles at default). Throughput is at most one result per BIN_W+3 cycles.
- in_ready=0 in all states except IDLE. Input is not sampled outside IDLE.
- in_valid may drop without acceptance, with no effect. in_float32 only needs to be stable at the accepting edge.
- Arithmetic is unsigned on magnitude. Sign handling uses the sign bit only.

Decomposition:
- fpu_pkg (shared):
  - float32_t struct {sign, exp[7:0], frac[22:0]}
  - EXP_BIAS=127, FRAC_W=23, EXP_INF_NAN=8'hFF
  - BCD digit typedef (logic[3:0])
  - fsm state enum for this block
- One combinational sub-module: bcd_dd_step (one double-dabble iteration: per-digit add-3 then 1-bit shift), instanced once inside CONVERT.

Test Plan:
- 0x42D20000 (105.0), out_ready=1 -> out_bcd=0x1050, neg=0, ovf=0; out_valid exactly 15 cycles after accept edge, for 1 cycle; in_ready=1 next cycle.
- 0xC2200000 (-40.0) -> 0x0400, neg=1, ovf=0. 0x42C53333 (98.6) -> 0x0986 (rounding check). 0x3D4CCCCD (0.05) -> 0x0001 (half-up).
- 0x80000000 (-0.0) -> 0x0000, neg=0. 0x00000001 (denormal) -> 0x0000, neg=0, ovf=0.
- 0x447A0000 (1000.0) -> 0x9999, ovf=1, neg=0. 0xC47A0000 -> 0x9999, ovf=1, neg=1. 0x7FC00000 (NaN) and 0x7F800000 (Inf) -> 0x9999, ovf=1, neg=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid/out_bcd stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Reset mid-operation: rst=1 for 1 cycle at 6 cycles after accept -> next cycle state IDLE, out_valid=0, out_bcd=0, in_ready=1 once rst=0. A following 105.0 still yields 0x1050 with full 15-cycle latency.
